frame_dump_tx: RTL and testbench
================================

Name: frame_dump_tx

Overview:
Reads the full framebuffer out of the image BRAM and transmits it back to the host over UART (8N1). It is the read-back counterpart of the UART→BRAM image loader, and it drives a BRAM read port separate from the VGA read port. Each frame is sent as: 2 sync bytes, NUM_PIXELS pixel bytes in address order, then 1 checksum byte. It is triggered by a start pulse from a debounced key or a host command decoder.

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
BAUD, 115200, UART bit rate; bit period BAUD_DIV = CLK_FREQ/BAUD, integer division (434 at defaults)
NUM_PIXELS, 307200, number of bytes dumped, addresses 0..NUM_PIXELS-1
ADDR_W, 19, BRAM address width
RD_LATENCY, 2, cycles from rd_en/rd_addr to valid rd_data; legal range 1..3

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a dump when idle
abort  in  1  single-cycle pulse; stops the dump at the next byte boundary
rd_addr  out  ADDR_W  BRAM read address
rd_en  out  1  one-cycle read strobe
rd_data  in  8  BRAM read data, valid RD_LATENCY cycles after rd_en
tx  out  1  UART serial output, idle high
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse after the checksum stop bit completes
aborted  out  1  one-cycle pulse when an abort completes

Behaviour:
- Reset (async, active-high): tx=1, busy=0, done=0, aborted=0, rd_en=0, rd_addr=0. FSM goes to IDLE, checksum=0, UART tx sub-block goes idle. A reset mid-character drives tx high immediately; no partial character is completed.
- The FSM has 7 states:
  - IDLE: on start && !abort, go to SYNC0, clear checksum, set rd_addr=0. A start while busy is ignored. If start and abort arrive in the same cycle in IDLE, abort wins and nothing starts.
  - SYNC0: send 0xAA, then go to SYNC1.
  - SYNC1: send 0x55, then go to READ.
  - READ: pulse rd_en for 1 cycle at rd_addr, then go to WAIT_RD.
  - WAIT_RD: count RD_LATENCY cycles, latch rd_data into a byte register, then go to SEND_PIX.
  - SEND_PIX: hand the byte to the UART; checksum += byte, mod 256. If rd_addr == NUM_PIXELS-1, go to SEND_SUM; otherwise increment rd_addr and go to READ. The next read overlaps with the current character.
  - SEND_SUM: send the checksum byte; when its stop bit ends, pulse done and go to IDLE.
- The UART handshake is tx_start/tx_ready. A byte is accepted only when tx_ready=1. The FSM holds the byte until it is accepted.
- Character format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV clocks, so a character is 10*BAUD_DIV clocks. Consecutive characters are back-to-back with no idle gap.
- abort while busy: latched. The character in flight finishes in full. The FSM then returns to IDLE with no checksum sent, done=0, and aborted pulses. rd_addr returns to 0.
- rd_addr never exceeds NUM_PIXELS-1. There is no wrap-around in a dump, and every dump restarts at address 0.
- Throughput: one byte per character time. BRAM reads never stall the UART.

Decomposition:
- Shared package frame_dump_pkg holds:
  - SYNC0=8'hAA and SYNC1=8'h55
  - the FSM state encoding, 3-bit localparams
  - the BAUD_DIV computation
- One sub-module, uart_tx_byte: the baud counter, bit counter and shift register. Its interface is clk, reset, tx_start, tx_data[7:0], tx_ready, tx.

Test Plan:
- Basic frame: CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10), NUM_PIXELS=4, RD_LATENCY=2, mem={10,20,30,40}h; pulse start -> tx carries AA 55 10 20 30 40 A0. Every bit lasts 10 clocks and each frame is 100 clocks. done pulses exactly once, 700 clocks after the first start bit. busy then drops.
- Checksum wrap: mem={FF,FF,FF,FF} -> checksum byte = FC.
- start while busy: pulse start again during pixel 2 -> the stream is unchanged and exactly 7 bytes are sent.
- Abort: abort during the 0x10 character -> received bytes are AA 55 10 with the 0x10 frame complete. aborted pulses, done stays 0, tx stays high, and busy=0 after the stop bit.
- Reset mid-operation: assert reset in the middle of a data bit -> tx=1, busy=0 and rd_addr=0 immediately, with no clock edge required. A subsequent start produces a full correct dump.
- Latency sweep: RD_LATENCY=1 and RD_LATENCY=3 with the basic-frame memory -> identical byte stream and identical timing; rd_en asserts once per address, 4 pulses total.

Source files
------------

// File: rtl/frame_dump_pkg.sv
// Shared constants and types for the framebuffer read-back transmitter.
package frame_dump_pkg;

  // Sync bytes that open every dumped frame.
  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  // Dump sequencer states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SYNC0    = 3'd1,
    S_SYNC1    = 3'd2,
    S_READ     = 3'd3,
    S_WAIT_RD  = 3'd4,
    S_SEND_PIX = 3'd5,
    S_SEND_SUM = 3'd6
  } state_t;

  // Clocks per UART bit; integer division truncates.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter. tx_ready is also high during the last clock of the
// stop bit, so a byte offered then starts with no idle gap.
module uart_tx_byte
  import frame_dump_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic             active;
  logic [9:0]       shreg;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic             bit_end;
  logic             char_end;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign char_end = bit_end && (bit_cnt == 4'd9);
  assign tx_ready = !active || char_end;
  // Line driven straight from a flop; idle shifter holds all ones.
  assign tx       = shreg[0];

  // Load a frame on handshake, otherwise step baud and bit counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tx_start && tx_ready) begin
      // NOTE: non-blocking here so every flop samples pre-edge values; blocking would chain updates within the edge.
      active   <= 1'b1;
      shreg    <= {1'b1, tx_data, 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        shreg    <= {1'b1, shreg[9:1]};
        if (bit_cnt == 4'd9) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_dump_tx.sv
// Framebuffer dump: sends AA 55, NUM_PIXELS bytes read from BRAM in address
// order, then a mod-256 checksum over UART 8N1. Pixel reads overlap the
// character in flight so the line never idles inside a frame.
module frame_dump_tx
  import frame_dump_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int NUM_PIXELS = 307200,
  parameter int ADDR_W     = 19,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [7:0]        rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t      state;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        uart_start;
  logic        accept;
  logic [7:0]  checksum;
  logic [1:0]  lat_cnt;
  logic        sum_sent;
  logic        abort_pend;

  // NOTE: a pending byte is withheld as soon as abort is seen, so a byte offered in the same cycle never slips out.
  assign uart_start = tx_start && !abort_pend && !abort;
  assign accept     = uart_start && tx_ready;

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .reset   (reset),
    .tx_start(uart_start),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx)
  );

  // Dump sequencer with registered strobes, handshake and read address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      checksum   <= '0;
      lat_cnt    <= '0;
      sum_sent   <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      rd_en   <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state == S_IDLE) begin
        if (start && !abort) begin
          state    <= S_SYNC0;
          busy     <= 1'b1;
          checksum <= '0;
          rd_addr  <= '0;
          sum_sent <= 1'b0;
          tx_data  <= SYNC0;
          tx_start <= 1'b1;
        end
      end else if (abort_pend || abort) begin
        // Let the character in flight finish, then drop back to idle.
        abort_pend <= 1'b1;
        if (tx_ready) begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          aborted    <= 1'b1;
          abort_pend <= 1'b0;
          tx_start   <= 1'b0;
          sum_sent   <= 1'b0;
          rd_addr    <= '0;
        end
      end else begin
        case (state)
          S_SYNC0: begin
            if (accept) begin
              tx_data <= SYNC1;
              state   <= S_SYNC1;
            end
          end
          S_SYNC1: begin
            if (accept) begin
              tx_start <= 1'b0;
              state    <= S_READ;
            end
          end
          S_READ: begin
            rd_en   <= 1'b1;
            lat_cnt <= '0;
            state   <= S_WAIT_RD;
          end
          S_WAIT_RD: begin
            if (lat_cnt == LAT) begin
              tx_data  <= rd_data;
              tx_start <= 1'b1;
              state    <= S_SEND_PIX;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          S_SEND_PIX: begin
            if (accept) begin
              tx_start <= 1'b0;
              checksum <= checksum + tx_data;
              if (rd_addr == LAST_ADDR) begin
                state <= S_SEND_SUM;
              end else begin
                rd_addr <= rd_addr + 1'b1;
                state   <= S_READ;
              end
            end
          end
          S_SEND_SUM: begin
            if (!sum_sent) begin
              if (!tx_start) begin
                tx_data  <= checksum;
                tx_start <= 1'b1;
              end else if (accept) begin
                tx_start <= 1'b0;
                sum_sent <= 1'b1;
              end
            end else if (tx_ready) begin
              // tx_ready here marks the final clock of the checksum stop bit.
              done     <= 1'b1;
              busy     <= 1'b0;
              sum_sent <= 1'b0;
              rd_addr  <= '0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_dump_tx.sv
// Bench for frame_dump_tx: three instances (read latency 1, 2, 3) share
// stimulus; the latency-2 instance is decoded by a UART receiver and scored
// against expected bytes, the others must match it cycle for cycle.
module tb_frame_dump_tx;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD       = 100;
  localparam int NUM_PIXELS = 4;
  localparam int ADDR_W     = 3;
  localparam int CHAR_CLKS  = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] mem [8];
  logic [7:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // DUT instances with per-latency BRAM models and read-strobe monitors.
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int LAT = g + 1;
    logic              tx, busy, done, aborted, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        pipe [1:3];
    int                cnt = 0;
    int                rd_frame = 0;
    int                addr_bad = 0;

    frame_dump_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .NUM_PIXELS(NUM_PIXELS),
      .ADDR_W    (ADDR_W),
      .RD_LATENCY(LAT)
    ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .abort  (abort),
      .rd_addr(rd_addr),
      .rd_en  (rd_en),
      .rd_data(rd_data),
      .tx     (tx),
      .busy   (busy),
      .done   (done),
      .aborted(aborted)
    );

    always @(posedge clk) begin
      pipe[1] <= rd_en ? mem[rd_addr] : 8'hEE;
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
    assign rd_data = pipe[LAT];

    always @(negedge clk) begin
      if (done) rd_frame <= cnt;
      if (rd_en) begin
        if (int'(rd_addr) != cnt) addr_bad <= addr_bad + 1;
        cnt <= cnt + 1;
      end else if (!busy) begin
        cnt <= 0;
      end
    end
  end

  // UART receiver / scoreboard on the latency-2 instance.
  bit         rx_busy = 0;
  bit         rx_bad;
  int         rx_start;
  logic [7:0] rx_exp;
  logic [7:0] rx_byte;
  int         rx_total = 0;
  int         frame_idx = 0;
  int         frame_start = 0;
  int         prev_start = 0;
  int         done_cnt = 0;
  int         abort_cnt = 0;
  int         diff_cnt = 0;
  int         k;
  logic       exp_bit;

  always @(negedge clk) begin
    if (reset) begin
      rx_busy   = 0;
      frame_idx = 0;
    end else begin
      if (inst[0].tx !== inst[1].tx || inst[2].tx !== inst[1].tx ||
          inst[0].busy !== inst[1].busy || inst[2].busy !== inst[1].busy ||
          inst[0].done !== inst[1].done || inst[2].done !== inst[1].done)
        diff_cnt++;
      if (!rx_busy && inst[1].tx == 1'b0) begin
        rx_busy  = 1;
        rx_start = cyc;
        rx_bad   = 0;
        rx_byte  = '0;
        check("char_expected", 32'(exp_q.size() != 0), 1);
        rx_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        if (frame_idx == 0) frame_start = cyc;
        else check("char_spacing", cyc - prev_start, CHAR_CLKS);
        prev_start = cyc;
      end
      if (rx_busy) begin
        k = cyc - rx_start;
        exp_bit = (k < 10) ? 1'b0 : (k < 90) ? rx_exp[k/10 - 1] : 1'b1;
        if (inst[1].tx !== exp_bit) rx_bad = 1;
        if (k % 10 == 5 && k >= 15 && k <= 85) rx_byte[k/10 - 1] = inst[1].tx;
        if (k == CHAR_CLKS - 1) begin
          rx_busy = 0;
          rx_total++;
          frame_idx++;
          check("rx_byte", rx_byte, rx_exp);
          check("bit_timing", 32'(rx_bad), 0);
        end
      end
      if (inst[1].done) begin
        done_cnt++;
        check("done_latency", cyc - frame_start, 7 * CHAR_CLKS);
        check("done_busy_low", inst[1].busy, 0);
        frame_idx = 0;
      end
      if (inst[1].aborted) begin
        abort_cnt++;
        check("aborted_busy_low", inst[1].busy, 0);
        check("aborted_tx_idle", inst[1].tx, 1);
        frame_idx = 0;
      end
    end
  end

  task automatic load_mem(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    for (int i = 4; i < 8; i++) mem[i] = 8'hBD;
  endtask

  // Reference frame: sync pair, pixels in order, byte-sum modulo 256.
  task automatic push_frame();
    int s;
    s = 0;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int i = 0; i < NUM_PIXELS; i++) begin
      exp_q.push_back(mem[i]);
      s = (s + int'(mem[i])) % 256;
    end
    exp_q.push_back(8'(s));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_rx(input int target, input string name);
    int n;
    n = 0;
    while (rx_total < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(rx_total >= target), 1);
  endtask

  task automatic run_frame(input bit restart_mid);
    int d0, r0, n;
    d0 = done_cnt;
    r0 = rx_total;
    n = 0;
    push_frame();
    pulse_start();
    check("busy_after_start", inst[1].busy, 1);
    if (restart_mid) begin
      wait_rx(r0 + 3, "wait_pixel");
      pulse_start();
    end
    while (done_cnt == d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_cnt - d0, 1);
    repeat (150) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("frame_bytes", rx_total - r0, 7);
    check("queue_drained", exp_q.size(), 0);
    check("busy_idle", inst[1].busy, 0);
    check("rd_addr_idle", inst[1].rd_addr, 0);
    check("rd_pulses_lat1", inst[0].rd_frame, NUM_PIXELS);
    check("rd_pulses_lat2", inst[1].rd_frame, NUM_PIXELS);
    check("rd_pulses_lat3", inst[2].rd_frame, NUM_PIXELS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, d0, a0, n;
    load_mem(8'h10, 8'h20, 8'h30, 8'h40);
    repeat (3) @(negedge clk);
    check("reset_tx", inst[1].tx, 1);
    check("reset_busy", inst[1].busy, 0);
    check("reset_done", inst[1].done, 0);
    check("reset_aborted", inst[1].aborted, 0);
    check("reset_rd_en", inst[1].rd_en, 0);
    check("reset_rd_addr", inst[1].rd_addr, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame, checksum wrap, restart while busy.
    run_frame(0);
    load_mem(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_frame(0);
    load_mem(8'h10, 8'h20, 8'h30, 8'h40);
    run_frame(1);

    // Abort during the first pixel character.
    r0 = rx_total; d0 = done_cnt; a0 = abort_cnt; n = 0;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h10);
    pulse_start();
    wait_rx(r0 + 2, "wait_sync");
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    while (abort_cnt == a0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("aborted_seen", abort_cnt - a0, 1);
    repeat (150) @(negedge clk);
    check("abort_bytes", rx_total - r0, 3);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_once", abort_cnt - a0, 1);
    check("abort_tx_high", inst[1].tx, 1);
    check("abort_busy", inst[1].busy, 0);
    check("abort_rd_addr", inst[1].rd_addr, 0);
    check("abort_queue", exp_q.size(), 0);

    // Start and abort together in idle: nothing starts.
    r0 = rx_total;
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    repeat (3) @(negedge clk);
    check("start_abort_busy", inst[1].busy, 0);
    repeat (120) @(negedge clk);
    check("start_abort_bytes", rx_total - r0, 0);

    // Reset in the middle of a data bit, then a clean dump.
    r0 = rx_total; d0 = done_cnt;
    push_frame();
    pulse_start();
    wait_rx(r0 + 3, "wait_mid");
    repeat (35) @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_tx_lat1", inst[0].tx, 1);
    check("midreset_tx_lat2", inst[1].tx, 1);
    check("midreset_tx_lat3", inst[2].tx, 1);
    check("midreset_busy", inst[1].busy, 0);
    check("midreset_rd_addr", inst[1].rd_addr, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midreset_no_done", done_cnt - d0, 0);
    repeat (5) @(negedge clk);
    run_frame(0);

    // Randomized frames.
    for (int r = 0; r < 5; r++) begin
      load_mem(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(1, 40)) @(negedge clk);
      run_frame(0);
    end

    check("latency_sweep_identical", diff_cnt, 0);
    check("rd_addr_seq_lat1", inst[0].addr_bad, 0);
    check("rd_addr_seq_lat2", inst[1].addr_bad, 0);
    check("rd_addr_seq_lat3", inst[2].addr_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
